// File: rtl/wishbone_pkg.sv
// Shared constants and state encoding for the Wishbone burst master.
package wishbone_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BUS = 2'd1,
        XFER     = 2'd2
    } wbm_state_t;

endpackage

// File: rtl/wbm_wait_timer.sv
// Loadable down-counter bounding how long the master waits for bus grant or ack.
module wbm_wait_timer #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic reload,
    input  logic dec,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Saturates at zero; the owner aborts on the first stalled cycle seen at zero.
    always_comb begin
        count_d = count_q;
        if (reload) begin
            count_d = CNT_MAX;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= CNT_MAX;
            expired <= (CNT_MAX == '0);
        end else begin
            count_q <= count_d;
            expired <= (count_d == '0);
        end
    end

endmodule

// File: rtl/wishbone_burst_master.sv
// Incrementing-burst Wishbone B4 master with per-beat timeout.
// Define WBM_ERR_EN to abort bursts on err_i; otherwise err_i is ignored.
module wishbone_burst_master
    import wishbone_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned SEL_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned MAX_PAYLOAD   = 8,
    parameter int unsigned ADDR_STRIDE   = 1,
    parameter int unsigned MAX_WAIT      = 8,
    parameter int unsigned LEN_W         = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    output logic [ADDRESS_WIDTH-1:0]          adr_o,
    input  logic [DATA_WIDTH-1:0]             dat_i,
    output logic [DATA_WIDTH-1:0]             dat_o,
    output logic                              we_o,
    output logic [SEL_WIDTH-1:0]              sel_o,
    output logic                              stb_o,
    output logic                              cyc_o,
    output logic [2:0]                        cti_o,
    output logic [1:0]                        bte_o,
    input  logic                              cyc_i,
    input  logic                              ack_i,
    input  logic                              err_i,
    input  logic [ADDRESS_WIDTH-1:0]          transfer_address,
    input  logic [MAX_PAYLOAD*DATA_WIDTH-1:0] payload_in,
    output logic [MAX_PAYLOAD*DATA_WIDTH-1:0] payload_out,
    input  logic [LEN_W-1:0]                  payload_length,
    input  logic                              start_read,
    input  logic                              start_write,
    output logic                              busy,
    output logic                              completed,
    output logic                              timeout,
    output logic                              error
);

    localparam int unsigned PW = MAX_PAYLOAD * DATA_WIDTH;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_PAYLOAD);

    wbm_state_t                state_q, state_d;
    logic [LEN_W-1:0]          beat_q, beat_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic [ADDRESS_WIDTH-1:0]  base_q, base_d;
    logic                      write_q, write_d;
    logic [PW-1:0]             wdata_q, wdata_d;
    logic [PW-1:0]             rdata_d;
    logic                      completed_d, timeout_d, error_d;
    logic                      cyc_d, we_d;
    logic [SEL_WIDTH-1:0]      sel_d;
    logic [2:0]                cti_d;
    logic [ADDRESS_WIDTH-1:0]  adr_d;
    logic [DATA_WIDTH-1:0]     dat_d;
    logic                      drive_c;
    logic                      tmr_reload_c, tmr_dec_c, tmr_expired;
    logic [LEN_W-1:0]          len_in_c;
    logic [LEN_W-1:0]          last_beat_c;

    assign bte_o       = BTE_LINEAR;
    assign len_in_c    = (payload_length > LEN_MAX) ? LEN_MAX : payload_length;
    assign last_beat_c = len_q - LEN_W'(1);

`ifndef WBM_ERR_EN
    logic unused_err_c;
    assign unused_err_c = err_i;
`endif

    wbm_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .reload  (tmr_reload_c),
        .dec     (tmr_dec_c),
        .expired (tmr_expired)
    );

    // Next-state, datapath and next bus-output computation.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        len_d        = len_q;
        base_d       = base_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        rdata_d      = payload_out;
        completed_d  = completed;
        timeout_d    = timeout;
        error_d      = error;
        drive_c      = 1'b0;
        tmr_reload_c = 1'b1;
        tmr_dec_c    = 1'b0;
        cyc_d        = 1'b0;
        we_d         = 1'b0;
        sel_d        = '0;
        cti_d        = CTI_CLASSIC;
        adr_d        = '0;
        dat_d        = '0;

        unique case (state_q)
            IDLE: begin
                if (start_read || start_write) begin
                    base_d      = transfer_address;
                    wdata_d     = payload_in;
                    write_d     = !start_read;
                    len_d       = len_in_c;
                    beat_d      = '0;
                    completed_d = (len_in_c == '0);
                    timeout_d   = 1'b0;
                    error_d     = 1'b0;
                    if (len_in_c != '0) begin
                        state_d = WAIT_BUS;
                    end
                end
            end
            WAIT_BUS: begin
                if (!cyc_i) begin
                    state_d = XFER;
                    beat_d  = '0;
                    drive_c = 1'b1;
                end else begin
                    tmr_reload_c = 1'b0;
                    tmr_dec_c    = 1'b1;
                    if (tmr_expired) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            XFER: begin
`ifdef WBM_ERR_EN
                if (err_i) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else
`endif
                if (ack_i) begin
                    if (!write_q) begin
                        rdata_d[int'(beat_q)*DATA_WIDTH +: DATA_WIDTH] = dat_i;
                    end
                    if (beat_q == last_beat_c) begin
                        completed_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        beat_d  = beat_q + LEN_W'(1);
                        drive_c = 1'b1;
                    end
                end else begin
                    tmr_reload_c = 1'b0;
                    tmr_dec_c    = 1'b1;
                    if (tmr_expired) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        drive_c = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Bus outputs for the beat that will be on the bus next cycle.
        if (drive_c) begin
            cyc_d = 1'b1;
            we_d  = write_q;
            sel_d = '1;
            adr_d = base_q + ADDRESS_WIDTH'(ADDRESS_WIDTH'(beat_d) * ADDRESS_WIDTH'(ADDR_STRIDE));
            cti_d = (beat_d == last_beat_c) ? CTI_END : CTI_INCR;
            if (write_q) begin
                dat_d = wdata_q[int'(beat_d)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            len_q       <= '0;
            base_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            payload_out <= '0;
            completed   <= 1'b0;
            timeout     <= 1'b0;
            error       <= 1'b0;
            busy        <= 1'b0;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            sel_o       <= '0;
            cti_o       <= CTI_CLASSIC;
            adr_o       <= '0;
            dat_o       <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            len_q       <= len_d;
            base_q      <= base_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            payload_out <= rdata_d;
            completed   <= completed_d;
            timeout     <= timeout_d;
            error       <= error_d;
            busy        <= (state_d != IDLE);
            cyc_o       <= cyc_d;
            stb_o       <= cyc_d;
            we_o        <= we_d;
            sel_o       <= sel_d;
            cti_o       <= cti_d;
            adr_o       <= adr_d;
            dat_o       <= dat_d;
        end
    end

endmodule

// File: tb/tb_wishbone_burst_master.sv
// Directed bench for wishbone_burst_master: 32-bit data, stride 4, 16-bit address.
module tb_wishbone_burst_master;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned MP = 8;
    localparam int unsigned PW = MP * DW;

`ifdef WBM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [AW-1:0] adr_o;
    logic [DW-1:0] dat_i = '0;
    logic [DW-1:0] dat_o;
    logic          we_o;
    logic [3:0]    sel_o;
    logic          stb_o, cyc_o;
    logic [2:0]    cti_o;
    logic [1:0]    bte_o;
    logic          cyc_i = 1'b0;
    logic          ack_i = 1'b0;
    logic          err_i = 1'b0;
    logic [AW-1:0] transfer_address = '0;
    logic [PW-1:0] payload_in = '0;
    logic [PW-1:0] payload_out;
    logic [3:0]    payload_length = '0;
    logic          start_read = 1'b0, start_write = 1'b0;
    logic          busy, completed, timeout, error;

    int errors = 0;
    int checks = 0;
    logic [PW-1:0] pout_m = '0;

    always #5 clk_i = ~clk_i;

    wishbone_burst_master #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .MAX_PAYLOAD   (MP),
        .ADDR_STRIDE   (4),
        .MAX_WAIT      (8)
    ) dut (
        .clk_i (clk_i), .rst_i (rst_i), .adr_o (adr_o), .dat_i (dat_i), .dat_o (dat_o),
        .we_o (we_o), .sel_o (sel_o), .stb_o (stb_o), .cyc_o (cyc_o), .cti_o (cti_o),
        .bte_o (bte_o), .cyc_i (cyc_i), .ack_i (ack_i), .err_i (err_i),
        .transfer_address (transfer_address), .payload_in (payload_in),
        .payload_out (payload_out), .payload_length (payload_length),
        .start_read (start_read), .start_write (start_write), .busy (busy),
        .completed (completed), .timeout (timeout), .error (error)
    );

    typedef struct {
        bit          rd;
        bit          both;
        logic [15:0] base;
        logic [3:0]  len;
        int          eff_len;
        int          stall_beat;
        int          stalls;
        int          err_beat;
        int          exp_cycles;
        bit          exp_done;
        bit          exp_tmo;
        bit          exp_err;
    } burst_t;

    burst_t vecs [8];

    task automatic chk(input string nm, input int idx, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got 0x%0h want 0x%0h", nm, idx, act, exp);
        end
    endtask

    function automatic logic [31:0] slave_data(input int idx, input logic [15:0] a);
        return {8'(idx), 8'hD5, a};
    endfunction

    function automatic logic [31:0] wr_word(input int idx, input int k);
        return {8'(idx), 8'h7E, 8'(k), 8'h3C};
    endfunction

    task automatic load_payload(input int idx);
        for (int k = 0; k < int'(MP); k++) payload_in[k*DW +: DW] = wr_word(idx, k);
    endtask

    // Plays start, acts as the slave and checks every bus cycle of one burst.
    task automatic run_burst(input burst_t v, input int idx);
        int cycles = 0;
        int k = 0;
        int stalled = 0;
        bit done = 1'b0;
        logic [15:0] ea;
        load_payload(idx);
        transfer_address = v.base;
        payload_length   = v.len;
        start_read       = v.rd | v.both;
        start_write      = !v.rd | v.both;
        @(posedge clk_i); #1;
        start_read  = 1'b0;
        start_write = 1'b0;
        for (int t = 0; t < 40 && !done; t++) begin
            ack_i = 1'b0;
            err_i = 1'b0;
            dat_i = '0;
            if (cyc_o) begin
                cycles++;
                ea = 16'(v.base + 16'(k * 4));
                chk("adr", idx, PW'(adr_o), PW'(ea));
                chk("cti", idx, PW'(cti_o), PW'((k < v.eff_len - 1) ? 3'b010 : 3'b111));
                chk("ctl", idx, PW'({stb_o, we_o, sel_o}), PW'({1'b1, !v.rd, 4'hF}));
                chk("dat_o", idx, PW'(dat_o), PW'(v.rd ? 32'h0 : wr_word(idx, k)));
                if (k == v.stall_beat && stalled < v.stalls) begin
                    stalled++;
                end else begin
                    ack_i = 1'b1;
                    dat_i = slave_data(idx, ea);
                    if (k == v.err_beat) err_i = 1'b1;
                    if (!(err_i && ERR_EN)) begin
                        if (v.rd) pout_m[k*DW +: DW] = dat_i;
                        k++;
                    end
                end
            end else if (!busy) begin
                done = 1'b1;
            end
            if (!done) begin
                @(posedge clk_i); #1;
            end
        end
        ack_i = 1'b0;
        err_i = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL burst_end[%0d]: still busy after 40 cycles", idx);
        end
        chk("xfer_cycles", idx, PW'(cycles), PW'(v.exp_cycles));
        chk("status", idx, PW'({completed, timeout, error}), PW'({v.exp_done, v.exp_tmo, v.exp_err}));
        chk("payload_out", idx, payload_out, pout_m);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_bus"}, 0, PW'({cyc_o, stb_o, we_o, sel_o, cti_o, bte_o}), '0);
        chk({nm, "_adr_dat"}, 0, PW'({adr_o, dat_o}), '0);
        chk({nm, "_status"}, 0, PW'({busy, completed, timeout, error}), '0);
        chk({nm, "_payload_out"}, 0, payload_out, '0);
    endtask

    initial begin
        int cnt;
        bit seen_cyc;
        // rd both base len eff stall_beat stalls err_beat cycles done tmo err
        vecs[0] = '{1, 0, 16'h0100, 4'd4,  4, -1,   0, -1, 4, 1, 0, 0};
        vecs[1] = '{0, 0, 16'h0200, 4'd3,  3,  1,   2, -1, 5, 1, 0, 0};
        vecs[2] = '{1, 0, 16'hFFFC, 4'd2,  2, -1,   0, -1, 2, 1, 0, 0};
        vecs[3] = '{1, 0, 16'h0040, 4'd0,  0, -1,   0, -1, 0, 1, 0, 0};
        vecs[4] = '{0, 0, 16'h0300, 4'd15, 8, -1,   0, -1, 8, 1, 0, 0};
        vecs[5] = '{1, 1, 16'h0010, 4'd1,  1, -1,   0, -1, 1, 1, 0, 0};
        vecs[6] = '{1, 0, 16'h0700, 4'd2,  2,  0, 100, -1, 9, 0, 1, 0};
        vecs[7] = '{1, 0, 16'h0800, 4'd4,  4, -1,   0,  2, ERR_EN ? 3 : 4, !ERR_EN, 0, ERR_EN};

        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk_all_zero("reset");

        for (int i = 0; i < 8; i++) run_burst(vecs[i], i);

        // Another master keeps the bus: grant never comes, timeout after 9 waits.
        cyc_i = 1'b1;
        transfer_address = 16'h0500;
        payload_length   = 4'd2;
        start_read       = 1'b1;
        @(posedge clk_i); #1;
        start_read = 1'b0;
        cnt = 0;
        seen_cyc = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (cyc_o) seen_cyc = 1'b1;
            if (busy) cnt++;
            @(posedge clk_i); #1;
        end
        cyc_i = 1'b0;
        chk("grant_cyc_seen", 0, PW'(seen_cyc), '0);
        chk("grant_wait_cycles", 0, PW'(cnt), PW'(9));
        chk("grant_status", 0, PW'({busy, completed, timeout, error}), PW'(4'b0010));

        // Reset in the middle of a write burst releases the bus at once.
        load_payload(9);
        transfer_address = 16'h0600;
        payload_length   = 4'd4;
        start_write      = 1'b1;
        @(posedge clk_i); #1;
        start_write = 1'b0;
        cnt = 0;
        while (!cyc_o && cnt < 10) begin
            @(posedge clk_i); #1;
            cnt++;
        end
        chk("rst_mid_cyc", 0, PW'(cyc_o), PW'(1));
        ack_i = 1'b1;
        @(posedge clk_i); #1;
        chk("rst_mid_adr", 0, PW'(adr_o), PW'(16'h0604));
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        ack_i = 1'b0;
        pout_m = '0;
        chk_all_zero("rst_mid");

        run_burst(vecs[0], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
